// File: rtl/panel_scan_pkg.sv
// Shared types and width helpers for the panel scan driver.
// Imported by the sequencer and the top level.
package panel_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    SHIFT,
    LATCH,
    BLANK
  } scan_state_t;

  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int data_w(input int colors, input int bits);
    return colors * bits;
  endfunction

endpackage

// File: rtl/altera_dual_port_ram_simple.sv
// Simple dual-port block RAM, one write port and one registered read port.
// Read-during-write to the same address returns the old data.
module altera_dual_port_ram_simple #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

  // write port and registered read port
  always_ff @(posedge clk) begin
    if (we) ram[write_addr] <= data;
    q <= ram[read_addr];
  end

endmodule

// File: rtl/panel_scan_sequencer.sv
// Scan FSM: row, column and PWM slot counters, bank select, strobes.
// Panel strobes are registered copies of the current state.
module panel_scan_sequencer
  import panel_scan_pkg::*;
#(
  parameter  int NUM_COLUMNS = 16,
  parameter  int NUM_ROWS    = 16,
  parameter  int PWM_BITS    = 8,
  localparam int RAW         = addr_w(NUM_ROWS),
  localparam int CAW         = addr_w(NUM_COLUMNS),
  localparam int AW          = RAW + CAW + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                swap_req,
  output logic [AW-1:0]       rd_addr,
  output logic                phase_a,
  output logic                shifting,
  output logic [PWM_BITS-1:0] slot,
  output logic                disp_bank,
  output logic                swap_ack,
  output logic                frame_start,
  output logic                serial_clk,
  output logic                latch,
  output logic                blank,
  output logic [RAW-1:0]      row_sel
);

  localparam logic [CAW-1:0] COL_TOP = CAW'(NUM_COLUMNS - 1);
  localparam logic [RAW-1:0] ROW_TOP = RAW'(NUM_ROWS - 1);
  localparam logic [PWM_BITS-1:0] SLOT_LAST =
    PWM_BITS'(2**PWM_BITS - 2);

  scan_state_t         state, state_d;
  logic [CAW-1:0]      col, col_d;
  logic                ph_b, ph_b_d;
  logic [PWM_BITS-1:0] slot_d;
  logic [RAW-1:0]      row, row_d;
  logic                bank_d;
  logic                pending, pend_d;
  logic                take;
  logic [CAW-1:0]      rd_col;

  assign shifting = (state == SHIFT);
  assign phase_a  = shifting && !ph_b;
  assign rd_col   = shifting ? col - CAW'(1) : COL_TOP;
  assign rd_addr  = {disp_bank, row, rd_col};

  // state and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      col       <= '0;
      ph_b      <= 1'b0;
      slot      <= '0;
      row       <= '0;
      disp_bank <= 1'b0;
      pending   <= 1'b0;
    end else begin
      state     <= state_d;
      col       <= col_d;
      ph_b      <= ph_b_d;
      slot      <= slot_d;
      row       <= row_d;
      disp_bank <= bank_d;
      pending   <= pend_d;
    end
  end

  // next-state, counter stepping and swap at frame wrap
  always_comb begin
    state_d = state;
    col_d   = col;
    ph_b_d  = ph_b;
    slot_d  = slot;
    row_d   = row;
    bank_d  = disp_bank;
    pend_d  = pending | swap_req;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) state_d = PREFETCH;
      end
      PREFETCH: begin
        state_d = SHIFT;
        col_d   = COL_TOP;
        ph_b_d  = 1'b0;
        slot_d  = '0;
      end
      SHIFT: begin
        ph_b_d = !ph_b;
        if (ph_b) begin
          if (col == '0) state_d = LATCH;
          else           col_d   = col - CAW'(1);
        end
      end
      LATCH: begin
        if (slot < SLOT_LAST) begin
          state_d = SHIFT;
          slot_d  = slot + PWM_BITS'(1);
          col_d   = COL_TOP;
          ph_b_d  = 1'b0;
        end else begin
          state_d = BLANK;
        end
      end
      BLANK: begin
        row_d   = (row == ROW_TOP) ? '0 : row + RAW'(1);
        state_d = enable ? PREFETCH : IDLE;
        if (row == ROW_TOP && pending) begin
          take   = 1'b1;
          bank_d = !disp_bank;
          pend_d = swap_req;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // registered panel strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      serial_clk  <= 1'b0;
      latch       <= 1'b0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;
      row_sel     <= '0;
    end else begin
      serial_clk  <= shifting && ph_b;
      latch       <= (state == LATCH);
      blank       <= (state == IDLE) || (state == BLANK);
      frame_start <= (state == PREFETCH) && (row == '0);
      swap_ack    <= take;
      row_sel     <= row_d;
    end
  end

endmodule

// File: rtl/panel_scan_driver.sv
// Self-sequencing LED panel driver with a double-buffered frame RAM.
// Host writes the back bank; swaps land only on frame boundaries.
module panel_scan_driver
  import panel_scan_pkg::*;
#(
  parameter  int NUM_COLORS  = 3,
  parameter  int NUM_COLUMNS = 16,
  parameter  int NUM_ROWS    = 16,
  parameter  int PWM_BITS    = 8,
  localparam int RAW         = addr_w(NUM_ROWS),
  localparam int CAW         = addr_w(NUM_COLUMNS),
  localparam int DW          = data_w(NUM_COLORS, PWM_BITS),
  localparam int AW          = RAW + CAW + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [RAW-1:0]        wr_row,
  input  logic [CAW-1:0]        wr_col,
  input  logic [DW-1:0]         wr_data,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  frame_start,
  output logic [NUM_COLORS-1:0] serial_data_out,
  output logic                  serial_clk,
  output logic                  latch,
  output logic                  blank,
  output logic [RAW-1:0]        row_sel
);

  localparam logic [RAW:0] ROW_LIM = (RAW + 1)'(NUM_ROWS);
  localparam logic [CAW:0] COL_LIM = (CAW + 1)'(NUM_COLUMNS);

  logic [AW-1:0]         rd_addr;
  logic [AW-1:0]         wr_addr;
  logic [DW-1:0]         q;
  logic                  phase_a;
  logic                  shifting;
  logic [PWM_BITS-1:0]   slot;
  logic                  disp_bank;
  logic                  wr_ok;
  logic [NUM_COLORS-1:0] cmp;

  assign wr_ok = wr_en
              && ({1'b0, wr_row} < ROW_LIM)
              && ({1'b0, wr_col} < COL_LIM);
  assign wr_addr = {!disp_bank, wr_row, wr_col};

  altera_dual_port_ram_simple #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk        (clk),
    .we         (wr_ok),
    .write_addr (wr_addr),
    .read_addr  (rd_addr),
    .data       (wr_data),
    .q          (q)
  );

  panel_scan_sequencer #(
    .NUM_COLUMNS (NUM_COLUMNS),
    .NUM_ROWS    (NUM_ROWS),
    .PWM_BITS    (PWM_BITS)
  ) u_seq (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .swap_req    (swap_req),
    .rd_addr     (rd_addr),
    .phase_a     (phase_a),
    .shifting    (shifting),
    .slot        (slot),
    .disp_bank   (disp_bank),
    .swap_ack    (swap_ack),
    .frame_start (frame_start),
    .serial_clk  (serial_clk),
    .latch       (latch),
    .blank       (blank),
    .row_sel     (row_sel)
  );

  // per-channel PWM compare: lit while value exceeds the slot
  always_comb begin
    cmp = '0;
    for (int c = 0; c < NUM_COLORS; c++)
      cmp[c] = q[c*PWM_BITS +: PWM_BITS] > slot;
  end

  // load data in phase A, hold in phase B, idle low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      serial_data_out <= '0;
    else if (phase_a)  serial_data_out <= cmp;
    else if (!shifting) serial_data_out <= '0;
  end

endmodule

// File: tb/tb_panel_scan_driver.sv
// Directed bench for panel_scan_driver: 3 colours, 4x2, 2-bit PWM.
// Cycle-indexed vector table plus reset and restart sequences.
module tb_panel_scan_driver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       wr_en;
  logic [0:0] wr_row;
  logic [1:0] wr_col;
  logic [5:0] wr_data;
  logic       swap_req;
  logic       swap_ack;
  logic       frame_start;
  logic [2:0] serial_data_out;
  logic       serial_clk;
  logic       latch;
  logic       blank;
  logic [0:0] row_sel;

  panel_scan_driver #(
    .NUM_COLORS  (3),
    .NUM_COLUMNS (4),
    .NUM_ROWS    (2),
    .PWM_BITS    (2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .wr_en           (wr_en),
    .wr_row          (wr_row),
    .wr_col          (wr_col),
    .wr_data         (wr_data),
    .swap_req        (swap_req),
    .swap_ack        (swap_ack),
    .frame_start     (frame_start),
    .serial_data_out (serial_data_out),
    .serial_clk      (serial_clk),
    .latch           (latch),
    .blank           (blank),
    .row_sel         (row_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [5:0] ctl;
    bit         chk;
    logic [2:0] sdo;
  } vec_t;

  typedef struct {
    int         cyc;
    logic       en;
    logic       we;
    logic       row;
    logic [1:0] col;
    logic [5:0] data;
    logic       swp;
  } stim_t;

  vec_t  vq[$];
  stim_t sq[$];
  int    cyc;
  int    total = 0;
  int    bad = 0;

  function automatic logic [5:0] ctl_now();
    return {blank, latch, serial_clk, frame_start, swap_ack, row_sel};
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    wr_en    = 1'b0;
    swap_req = 1'b0;
    foreach (sq[k]) begin
      if (sq[k].cyc == cyc) begin
        enable   = sq[k].en;
        wr_en    = sq[k].we;
        wr_row   = sq[k].row;
        wr_col   = sq[k].col;
        wr_data  = sq[k].data;
        swap_req = sq[k].swp;
      end
    end
  endtask

  initial begin
    // ctl = {blank, latch, sclk, frame_start, swap_ack, row_sel}
    vq.push_back('{0,   6'b100000, 1, 3'b000});
    vq.push_back('{1,   6'b000100, 1, 3'b000});
    vq.push_back('{2,   6'b000000, 0, 3'b000});
    vq.push_back('{3,   6'b001000, 0, 3'b000});
    vq.push_back('{9,   6'b001000, 0, 3'b000});
    vq.push_back('{10,  6'b010000, 1, 3'b000});
    vq.push_back('{11,  6'b000000, 0, 3'b000});
    vq.push_back('{19,  6'b010000, 1, 3'b000});
    vq.push_back('{28,  6'b010000, 1, 3'b000});
    vq.push_back('{29,  6'b100001, 1, 3'b000});
    vq.push_back('{30,  6'b000001, 1, 3'b000});
    vq.push_back('{39,  6'b010001, 1, 3'b000});
    vq.push_back('{58,  6'b100000, 1, 3'b000});
    vq.push_back('{59,  6'b000100, 1, 3'b000});
    vq.push_back('{115, 6'b010001, 1, 3'b000});
    vq.push_back('{116, 6'b100010, 1, 3'b000});
    vq.push_back('{117, 6'b000100, 1, 3'b000});
    vq.push_back('{118, 6'b000000, 1, 3'b101});
    vq.push_back('{119, 6'b001000, 1, 3'b101});
    vq.push_back('{120, 6'b000000, 1, 3'b011});
    vq.push_back('{122, 6'b000000, 1, 3'b000});
    vq.push_back('{124, 6'b000000, 1, 3'b000});
    vq.push_back('{126, 6'b010000, 1, 3'b000});
    vq.push_back('{127, 6'b000000, 1, 3'b101});
    vq.push_back('{129, 6'b000000, 1, 3'b010});
    vq.push_back('{136, 6'b000000, 1, 3'b100});
    vq.push_back('{137, 6'b001000, 1, 3'b100});
    vq.push_back('{138, 6'b000000, 1, 3'b010});
    vq.push_back('{145, 6'b100001, 1, 3'b000});
    vq.push_back('{147, 6'b000001, 1, 3'b011});
    vq.push_back('{156, 6'b000001, 1, 3'b001});
    vq.push_back('{174, 6'b100000, 1, 3'b000});
    vq.push_back('{175, 6'b000100, 1, 3'b000});
    vq.push_back('{232, 6'b100010, 1, 3'b000});
    vq.push_back('{290, 6'b100010, 1, 3'b000});
    vq.push_back('{318, 6'b010000, 1, 3'b000});
    vq.push_back('{319, 6'b100001, 1, 3'b000});
    vq.push_back('{320, 6'b100001, 1, 3'b000});
    vq.push_back('{335, 6'b100001, 1, 3'b000});
    vq.push_back('{341, 6'b100001, 1, 3'b000});
    vq.push_back('{342, 6'b000001, 1, 3'b000});
    vq.push_back('{351, 6'b010001, 1, 3'b000});
    vq.push_back('{353, 6'b001001, 1, 3'b001});

    // data = {ch2, ch1, ch0}
    sq.push_back('{60,  1, 1, 0, 2'd3, 6'b110010, 0});
    sq.push_back('{61,  1, 1, 0, 2'd2, 6'b001101, 0});
    sq.push_back('{62,  1, 1, 0, 2'd1, 6'b000000, 0});
    sq.push_back('{63,  1, 1, 0, 2'd0, 6'b000000, 0});
    sq.push_back('{64,  1, 1, 1, 2'd3, 6'b000111, 0});
    sq.push_back('{70,  1, 0, 0, 2'd0, 6'b000000, 1});
    sq.push_back('{80,  1, 0, 0, 2'd0, 6'b000000, 1});
    sq.push_back('{180, 1, 0, 0, 2'd0, 6'b000000, 1});
    sq.push_back('{231, 1, 0, 0, 2'd0, 6'b000000, 1});
    sq.push_back('{300, 0, 0, 0, 2'd0, 6'b000000, 0});
    sq.push_back('{340, 1, 0, 0, 2'd0, 6'b000000, 0});

    reset_n  = 1'b0;
    enable   = 1'b0;
    wr_en    = 1'b0;
    wr_row   = '0;
    wr_col   = '0;
    wr_data  = '0;
    swap_req = 1'b0;
    cyc      = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", 32'(ctl_now()), 32'(6'b100000));
    check("reset_sdo", 32'(serial_data_out), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ctl", 32'(ctl_now()), 32'(6'b100000));
    enable = 1'b1;
    cyc    = -1;

    foreach (vq[v]) begin
      int guard = 0;
      while (cyc < vq[v].cyc && guard < 1000) begin
        tick();
        guard++;
      end
      if (cyc != vq[v].cyc) begin
        bad++;
        total++;
        $display("FAIL timeout: cycle %0d required %0d",
                 cyc, vq[v].cyc);
      end else begin
        check($sformatf("ctl@%0d", cyc),
              32'(ctl_now()), 32'(vq[v].ctl));
        if (vq[v].chk)
          check($sformatf("sdo@%0d", cyc),
                32'(serial_data_out), 32'(vq[v].sdo));
      end
    end

    check("bank_before_rst", 32'(dut.u_seq.disp_bank), 1);
    reset_n = 1'b0;
    #2;
    check("rst_mid_ctl", 32'(ctl_now()), 32'(6'b100000));
    check("rst_mid_sdo", 32'(serial_data_out), 0);
    check("rst_mid_bank", 32'(dut.u_seq.disp_bank), 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_ctl", 32'(ctl_now()), 32'(6'b100000));
    reset_n = 1'b1;
    tick();
    check("restart_idle", 32'(ctl_now()), 32'(6'b100000));
    tick();
    check("restart_fs", 32'(ctl_now()), 32'(6'b000100));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
